// File: rtl/mult_job_sequencer.sv
// Job front-end for the self-timed 4x4 shift/add multiplier: operand FIFO, Finish handshake, held result.
// Optional macro MULT_SEQ_CHECK_EN adds a local product cross-check driving o_out_mismatch.
module mult_job_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 63
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_in_valid,
  output logic       o_in_ready,
  input  logic [3:0] i_in_a,
  input  logic [3:0] i_in_b,
  output logic       o_mul_start,
  output logic [3:0] o_mul_a,
  output logic [3:0] o_mul_b,
  input  logic       i_mul_finish,
  input  logic [7:0] i_mul_product,
  output logic       o_out_valid,
  input  logic       i_out_ready,
  output logic [7:0] o_out_product,
  output logic       o_out_err,
  output logic       o_out_mismatch,
  output logic       o_busy
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [5:0]      TMO_MAX = 6'(TIMEOUT);
  localparam logic [AW:0]     PTR_ONE = (AW+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_DRAIN   = 3'd2,
    S_CAPTURE = 3'd3,
    S_ABORT   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_mem_a [DEPTH];
  logic [3:0]  r_mem_b [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  logic        r_fin_meta;
  logic        r_fin_s;
  logic        r_fin_q;
  logic        w_rise;
  logic        w_fall;

  logic [5:0]  r_tmo;
  logic        w_tmo_hit;
  logic        w_clr_start;
  logic        w_capture;
  logic        w_abort;

  logic        r_mul_start;
  logic [3:0]  r_mul_a;
  logic [3:0]  r_mul_b;
  logic        r_out_valid;
  logic [7:0]  r_out_product;
  logic        r_out_err;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push    = i_in_valid && !w_full;
  assign w_rise    = r_fin_s && !r_fin_q;
  assign w_fall    = !r_fin_s && r_fin_q;
  assign w_tmo_hit = (r_tmo == TMO_MAX);

  // Finish crosses from the multiplier's self-timed domain: two-flop sync plus edge-detect stage.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fin_meta <= 1'b0;
      r_fin_s    <= 1'b0;
      r_fin_q    <= 1'b0;
    end else begin
      r_fin_meta <= i_mul_finish;
      r_fin_s    <= r_fin_meta;
      r_fin_q    <= r_fin_s;
    end
  end

  // Operand storage; contents are don't-care until a pointer covers them.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_a[r_wptr[AW-1:0]] <= i_in_a;
      r_mem_b[r_wptr[AW-1:0]] <= i_in_b;
    end
  end

  // FIFO pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control strobes; a job is only popped when the output slot is free.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_clr_start = 1'b0;
    w_capture   = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && (!r_out_valid || i_out_ready)) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_ABORT;
        end else if (w_rise) begin
          w_clr_start = 1'b1;
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (w_tmo_hit) begin
          w_state_nxt = S_ABORT;
        end else if (w_fall) begin
          w_state_nxt = S_CAPTURE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_CAPTURE: begin
        w_capture   = 1'b1;
        w_state_nxt = S_IDLE;
      end
      S_ABORT: begin
        w_abort     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Multiplier drive: operands stay frozen for the whole job; tmo measures ISSUE+DRAIN time.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mul_start <= 1'b0;
      r_mul_a     <= 4'h0;
      r_mul_b     <= 4'h0;
      r_tmo       <= 6'd0;
    end else begin
      if (w_pop) begin
        r_mul_start <= 1'b1;
        r_mul_a     <= r_mem_a[r_rptr[AW-1:0]];
        r_mul_b     <= r_mem_b[r_rptr[AW-1:0]];
      end else if (w_clr_start || w_abort) begin
        r_mul_start <= 1'b0;
      end
      if (w_pop) begin
        r_tmo <= 6'd0;
      end else if ((r_state == S_ISSUE) || (r_state == S_DRAIN)) begin
        r_tmo <= r_tmo + 6'd1;
      end
    end
  end

  // Result holding register; a fresh load takes priority over the consumer's acknowledge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_valid   <= 1'b0;
      r_out_product <= 8'h00;
      r_out_err     <= 1'b0;
    end else if (w_capture) begin
      r_out_valid   <= 1'b1;
      r_out_product <= i_mul_product;
      r_out_err     <= 1'b0;
    end else if (w_abort) begin
      r_out_valid   <= 1'b1;
      r_out_product <= 8'h00;
      r_out_err     <= 1'b1;
    end else if (i_out_ready) begin
      r_out_valid   <= 1'b0;
    end
  end

`ifdef MULT_SEQ_CHECK_EN
  logic [7:0] w_ref_product;
  logic       r_out_mismatch;

  assign w_ref_product = {4'h0, r_mul_a} * {4'h0, r_mul_b};

  // Cross-check flag travels with the product it describes.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_out_mismatch <= 1'b0;
    end else if (w_capture) begin
      r_out_mismatch <= (i_mul_product != w_ref_product);
    end else if (w_abort) begin
      r_out_mismatch <= 1'b0;
    end
  end

  assign o_out_mismatch = r_out_mismatch;
`else
  assign o_out_mismatch = 1'b0;
`endif

  assign o_in_ready    = !w_full;
  assign o_mul_start   = r_mul_start;
  assign o_mul_a       = r_mul_a;
  assign o_mul_b       = r_mul_b;
  assign o_out_valid   = r_out_valid;
  assign o_out_product = r_out_product;
  assign o_out_err     = r_out_err;
  assign o_busy        = (r_state != S_IDLE) || !w_empty;

endmodule

// File: tb/tb_mult_job_sequencer.sv
// Directed bench for mult_job_sequencer with a behavioural self-timed multiplier model.
module tb_mult_job_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic       mul_start;
  logic [3:0] mul_a;
  logic [3:0] mul_b;
  logic       mul_finish;
  logic [7:0] mul_product;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_product;
  logic       out_err;
  logic       out_mismatch;
  logic       busy;

  int errors = 0;
  int checks = 0;

  logic       stall    = 1'b0;
  logic [7:0] prod_xor = 8'h00;

`ifdef MULT_SEQ_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  mult_job_sequencer #(.DEPTH(4), .TIMEOUT(63)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_a        (in_a),
    .i_in_b        (in_b),
    .o_mul_start   (mul_start),
    .o_mul_a       (mul_a),
    .o_mul_b       (mul_b),
    .i_mul_finish  (mul_finish),
    .i_mul_product (mul_product),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_product (out_product),
    .o_out_err     (out_err),
    .o_out_mismatch(out_mismatch),
    .o_busy        (busy)
  );

  // Multiplier model: Finish rises some time after start, O is latched and Finish falls once start drops.
  initial begin
    logic [7:0] p;
    mul_finish  = 1'b0;
    mul_product = 8'h00;
    forever begin
      @(posedge mul_start);
      if (!stall) begin
        #17;
        p = {4'h0, mul_a} * {4'h0, mul_b};
        mul_finish = 1'b1;
        wait (mul_start == 1'b0);
        #9;
        mul_product = p ^ prod_xor;
        #3;
        mul_finish = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int limit);
    int n;
    n = 0;
    while (!out_valid && n < limit) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_result(input string tag, input logic [7:0] prod, input logic err,
                               input logic mm);
    wait_valid(tag, 100);
    chk({tag, "_prod"}, 32'(out_product), 32'(prod));
    chk({tag, "_err"}, 32'(out_err), 32'(err));
    chk({tag, "_mismatch"}, 32'(out_mismatch), 32'(mm));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_clr"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 4'h0;
    in_b      = 4'h0;
    out_ready = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mul_start", 32'(mul_start), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_product", 32'(out_product), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_mismatch", 32'(out_mismatch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // T1: 14*11 = 154 = 0x9A; result left pending for the backpressure tests
    push(4'd14, 4'd11);
    tick();
    chk("t1_start", 32'(mul_start), 32'd1);
    chk("t1_mul_a", 32'(mul_a), 32'd14);
    chk("t1_mul_b", 32'(mul_b), 32'd11);
    wait_valid("t1", 100);
    chk("t1_prod", 32'(out_product), 32'h9A);
    chk("t1_err", 32'(out_err), 32'd0);
    chk("t1_start_low", 32'(mul_start), 32'd0);

    // T2: output blocked, so the FIFO fills after four accepts and the fifth is held
    in_valid = 1'b1;
    in_a = 4'd3;  in_b = 4'd5;  chk("t2_rdy1", 32'(in_ready), 32'd1); tick();
    in_a = 4'd15; in_b = 4'd15; chk("t2_rdy2", 32'(in_ready), 32'd1); tick();
    in_a = 4'd0;  in_b = 4'd9;  chk("t2_rdy3", 32'(in_ready), 32'd1); tick();
    in_a = 4'd7;  in_b = 4'd1;  chk("t2_rdy4", 32'(in_ready), 32'd1); tick();
    in_a = 4'd2;  in_b = 4'd8;  chk("t2_full", 32'(in_ready), 32'd0);
    tick();
    tick();
    chk("t2_held", 32'(in_ready), 32'd0);
    chk("t2_busy", 32'(busy), 32'd1);
    chk("t3_hold_prod", 32'(out_product), 32'h9A);
    chk("t3_hold_valid", 32'(out_valid), 32'd1);
    chk("t3_no_issue", 32'(mul_start), 32'd0);

    // Consume: pop happens this edge but the push against a full FIFO is refused
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t2_pop_start", 32'(mul_start), 32'd1);
    chk("t2_pop_a", 32'(mul_a), 32'd3);
    chk("t2_out_clr", 32'(out_valid), 32'd0);
    chk("t2_rdy_after_pop", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("t2_full_again", 32'(in_ready), 32'd0);

    // T3: first result held while out_ready stays low; next job waits
    wait_valid("t3_j1", 100);
    repeat (3) tick();
    chk("t3_j1_stable", 32'(out_product), 32'h0F);
    chk("t3_j1_still_valid", 32'(out_valid), 32'd1);
    chk("t3_j2_waits", 32'(mul_start), 32'd0);
    expect_result("j1", 8'h0F, 1'b0, 1'b0);
    chk("t3_j2_issue", 32'(mul_start), 32'd1);
    expect_result("j2", 8'hE1, 1'b0, 1'b0);
    expect_result("j3", 8'h00, 1'b0, 1'b0);
    expect_result("j4", 8'h07, 1'b0, 1'b0);
    expect_result("j5", 8'h10, 1'b0, 1'b0);
    chk("t3_idle", 32'(busy), 32'd0);

    // T4: Finish never rises; abort lands 65 edges after the issue edge
    stall = 1'b1;
    push(4'd6, 4'd6);
    tick();
    chk("t4_start", 32'(mul_start), 32'd1);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    chk("t4_cycles", 32'(n), 32'd65);
    chk("t4_err", 32'(out_err), 32'd1);
    chk("t4_prod", 32'(out_product), 32'h00);
    chk("t4_start_low", 32'(mul_start), 32'd0);
    stall = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(4'd9, 4'd9);
    expect_result("t4_next", 8'h51, 1'b0, 1'b0);

    // T5: reset while in DRAIN with a second job queued
    push(4'd13, 4'd12);
    push(4'd2, 4'd2);
    chk("t5_issue", 32'(mul_start), 32'd1);
    n = 0;
    while (mul_start && n < 100) begin
      tick();
      n++;
    end
    chk("t5_in_drain", 32'(mul_start), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_start", 32'(mul_start), 32'd0);
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    repeat (10) tick();
    chk("t5_dropped_start", 32'(mul_start), 32'd0);
    chk("t5_dropped_valid", 32'(out_valid), 32'd0);
    chk("t5_dropped_busy", 32'(busy), 32'd0);

    // T6: corrupted 15*15 flags a mismatch only when the checker is built in
    prod_xor = 8'h01;
    push(4'd15, 4'd15);
    expect_result("t6_bad", 8'hE0, 1'b0, CHECK_EN);
    prod_xor = 8'h00;
    push(4'd15, 4'd15);
    expect_result("t6_good", 8'hE1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
